// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one shared decoder, N common-anode
// digits, blanking gap at each slot start, digit values committed only at frame ends.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS     = 2,
  parameter int SLOT_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   enable_in,
  output logic [3:0]            dec_digit,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic                  frame_tick,
  output logic                  busy
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  generate
    if (N_DIGITS < 2) begin : g_bad_digits
      $error("seven_seg_scan_ctrl: N_DIGITS must be at least 2");
    end
    if ((BLANK_CYCLES < 0) || (BLANK_CYCLES >= SLOT_CYCLES)) begin : g_bad_blank
      $error("seven_seg_scan_ctrl: BLANK_CYCLES must be in [0, SLOT_CYCLES)");
    end
  endgenerate

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [4*N_DIGITS-1:0] sh_dig_r;
  logic [N_DIGITS-1:0]   sh_en_r;
  logic [4*N_DIGITS-1:0] ac_dig_r;
  logic [N_DIGITS-1:0]   ac_en_r;
  logic                  pending_r;

  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [4*N_DIGITS-1:0] ac_dig_nxt_s;
  logic [N_DIGITS-1:0]   ac_en_nxt_s;
  logic                  slot_end_s;
  logic                  frame_end_s;
  phase_t                phase_nxt_s;
  logic [N_DIGITS-1:0]   anode_nxt_s;
  logic [3:0]            dec_nxt_s;

  // Phase of the upcoming cycle; without a blank window the anode is lit all slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign phase_nxt_s = PH_ON;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
      assign phase_nxt_s = (cnt_nxt_s < BLANK_END) ? PH_BLANK : PH_ON;
    end
  endgenerate

  // Next scan position and the values the active bank will hold next cycle.
  always_comb begin
    slot_end_s  = (cnt_r == CNT_LAST);
    frame_end_s = slot_end_s && (idx_r == IDX_LAST);
    if (slot_end_s) begin
      cnt_nxt_s = '0;
      idx_nxt_s = (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_W'(1));
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
      idx_nxt_s = idx_r;
    end
    // A load landing on the frame's last cycle bypasses the shadow bank.
    if (frame_end_s && load) begin
      ac_dig_nxt_s = digits_in;
      ac_en_nxt_s  = enable_in;
    end else if (frame_end_s && pending_r) begin
      ac_dig_nxt_s = sh_dig_r;
      ac_en_nxt_s  = sh_en_r;
    end else begin
      ac_dig_nxt_s = ac_dig_r;
      ac_en_nxt_s  = ac_en_r;
    end
    anode_nxt_s = '1;
    if (phase_nxt_s == PH_ON) begin
      anode_nxt_s[idx_nxt_s] = ~ac_en_nxt_s[idx_nxt_s];
    end else begin
      anode_nxt_s = '1;
    end
    dec_nxt_s = ac_dig_nxt_s[{idx_nxt_s, 2'b00} +: 4];
  end

  // Scan state, double-buffered digit banks and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r      <= '0;
      idx_r      <= '0;
      sh_dig_r   <= '0;
      sh_en_r    <= '0;
      ac_dig_r   <= '0;
      ac_en_r    <= '0;
      pending_r  <= 1'b0;
      dec_digit  <= 4'h0;
      anode_n    <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      idx_r    <= idx_nxt_s;
      ac_dig_r <= ac_dig_nxt_s;
      ac_en_r  <= ac_en_nxt_s;
      if (load) begin
        sh_dig_r  <= digits_in;
        sh_en_r   <= enable_in;
        pending_r <= ~frame_end_s;
      end else if (frame_end_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      dec_digit  <= dec_nxt_s;
      anode_n    <= anode_nxt_s;
      frame_tick <= frame_end_s;
    end
  end

  assign busy = pending_r;

endmodule
